// File: rtl/conway_neighbor_sequencer_pkg.sv
// Shared types and default rule constants for the Conway neighbour sequencer.
package conway_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        EVAL,
        DONE
    } seq_state_t;

    localparam int DEFAULT_NUM_NEIGHBORS = 8;
    localparam int DEFAULT_BIRTH_COUNT   = 3;
    localparam int DEFAULT_SURVIVE_MIN   = 2;
    localparam int DEFAULT_SURVIVE_MAX   = 3;

endpackage

// File: rtl/conway_neighbor_sequencer_if.sv
// Request/result bundle between the grid-update controller (master) and the sequencer (slave).
interface conway_neighbor_sequencer_if
    import conway_pkg::*;
#(
    parameter int NUM_NEIGHBORS = DEFAULT_NUM_NEIGHBORS,
    parameter int COUNT_WIDTH   = $clog2(NUM_NEIGHBORS + 1)
);

    logic                     i_start;
    logic                     i_alive_in;
    logic [NUM_NEIGHBORS-1:0] i_neighbors;
    logic                     o_ready;
    logic [COUNT_WIDTH-1:0]   o_count;
    logic                     o_alive_out;
    logic                     o_done;

    modport master (
        output i_start, i_alive_in, i_neighbors,
        input  o_ready, o_count, o_alive_out, o_done
    );

    modport slave (
        input  i_start, i_alive_in, i_neighbors,
        output o_ready, o_count, o_alive_out, o_done
    );

endinterface

// File: rtl/conway_neighbor_sequencer_accumulator.sv
// Narrow live-neighbour counter: adds a single bit per cycle, with a synchronous clear.
module neighbor_accumulator #(
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    input  logic                   i_inc,
    output logic [COUNT_WIDTH-1:0] o_acc
);

    logic [COUNT_WIDTH-1:0] r_acc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else begin
            r_acc <= r_acc + COUNT_WIDTH'(i_inc);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/conway_neighbor_sequencer.sv
// Serial Conway cell evaluator: shifts neighbour bits into a narrow accumulator,
// then applies the birth/survival rule and pulses DONE with the registered result.
module conway_neighbor_sequencer
    import conway_pkg::*;
#(
    parameter int NUM_NEIGHBORS = DEFAULT_NUM_NEIGHBORS,
    parameter int BIRTH_COUNT   = DEFAULT_BIRTH_COUNT,
    parameter int SURVIVE_MIN   = DEFAULT_SURVIVE_MIN,
    parameter int SURVIVE_MAX   = DEFAULT_SURVIVE_MAX
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    conway_neighbor_sequencer_if.slave   bus
);

    localparam int COUNT_WIDTH = $clog2(NUM_NEIGHBORS + 1);

    seq_state_t               r_state;
    seq_state_t               w_next_state;
    logic [NUM_NEIGHBORS-1:0] r_shreg;
    logic [COUNT_WIDTH-1:0]   r_idx;
    logic [COUNT_WIDTH-1:0]   r_count;
    logic                     r_alive_q;
    logic                     r_alive_out;
    logic [COUNT_WIDTH-1:0]   w_acc;
    logic                     w_accept;
    logic                     w_last;
    logic                     w_inc;
    logic                     w_survive;
    logic                     w_birth;

    assign w_last    = (r_idx == COUNT_WIDTH'(NUM_NEIGHBORS - 1));
    assign w_inc     = (r_state == COUNT) & r_shreg[0];
    assign w_survive = (w_acc >= COUNT_WIDTH'(SURVIVE_MIN)) && (w_acc <= COUNT_WIDTH'(SURVIVE_MAX));
    assign w_birth   = (w_acc == COUNT_WIDTH'(BIRTH_COUNT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // START is only honoured in IDLE; requests while busy are dropped, not queued.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_accept     = 1'b1;
                    w_next_state = COUNT;
                end
            end
            COUNT:   if (w_last) w_next_state = EVAL;
            EVAL:    w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg     <= '0;
            r_idx       <= '0;
            r_alive_q   <= 1'b0;
            r_count     <= '0;
            r_alive_out <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shreg   <= bus.i_neighbors;
                r_alive_q <= bus.i_alive_in;
                r_idx     <= '0;
            end else if (r_state == COUNT) begin
                r_shreg <= r_shreg >> 1;
                r_idx   <= r_idx + COUNT_WIDTH'(1);
            end
            // Results persist from here until the next evaluation reaches EVAL.
            if (r_state == EVAL) begin
                r_count     <= w_acc;
                r_alive_out <= r_alive_q ? w_survive : w_birth;
            end
        end
    end

    neighbor_accumulator #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_acc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (w_accept),
        .i_inc   (w_inc),
        .o_acc   (w_acc)
    );

    assign bus.o_ready     = (r_state == IDLE);
    assign bus.o_done      = (r_state == DONE);
    assign bus.o_count     = r_count;
    assign bus.o_alive_out = r_alive_out;

endmodule
